// File: rtl/sync_updown_counter_mod.sv
// Programmable-modulus up/down counter with wrap/saturate modes and a clock-enable prescaler.
// Latency: q, tick and tc are registered and update one clk edge after the enabling inputs; at_max/at_zero are combinational.
// Backpressure: none; en low freezes both q and the prescaler phase, clr/load act regardless of en.
module sync_updown_counter_mod #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic                  clr,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic                  up_dn,
    input  logic                  sat,
    input  logic [WIDTH-1:0]      mod_max,
    input  logic [PRESCALE_W-1:0] div,
    output logic [WIDTH-1:0]      q,
    output logic                  tick,
    output logic                  tc,
    output logic                  at_max,
    output logic                  at_zero
);

    logic [WIDTH-1:0]      q_q, q_d;
    logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
    logic                  tick_q, tick_d;
    logic                  tc_q, tc_d;

    logic                  step;
    logic [WIDTH-1:0]      step_val;
    logic                  step_tc;
    logic [WIDTH-1:0]      load_clamped;

    // Prescaler compare: ">=" so that lowering div below the current phase counts as a match.
    always_comb begin
        step = en && !clr && !load && (pcnt_q >= div);
    end

    // Prescaler phase: cleared by clr/load, restarts on a step, frozen while en is low.
    always_comb begin
        pcnt_d = pcnt_q;
        if (clr || load) begin
            pcnt_d = '0;
        end else if (en) begin
            if (step) begin
                pcnt_d = '0;
            end else begin
                // Only reached when pcnt_q < div, so the increment cannot overflow.
                pcnt_d = pcnt_q + PRESCALE_W'(1);
            end
        end
    end

    // Result of one count step in the current direction and mode, plus its terminal-count flag.
    always_comb begin
        step_val = q_q;
        step_tc  = 1'b0;
        if (up_dn) begin
            if (q_q < mod_max) begin
                // q_q < mod_max guarantees q_q + 1 stays within WIDTH bits.
                step_val = q_q + WIDTH'(1);
                step_tc  = sat && ((q_q + WIDTH'(1)) == mod_max);
            end else if (sat) begin
                step_val = mod_max;
                step_tc  = 1'b0;
            end else begin
                step_val = '0;
                step_tc  = 1'b1;
            end
        end else begin
            if (q_q > mod_max) begin
                // Modulus shrank under the count: snap to the new top without signalling.
                step_val = mod_max;
                step_tc  = 1'b0;
            end else if (q_q == '0) begin
                if (sat) begin
                    step_val = '0;
                    step_tc  = 1'b0;
                end else begin
                    step_val = mod_max;
                    step_tc  = 1'b1;
                end
            end else begin
                step_val = q_q - WIDTH'(1);
                step_tc  = sat && (q_q == WIDTH'(1));
            end
        end
    end

    // Loaded value is clamped into the programmed range.
    always_comb begin
        load_clamped = (load_val > mod_max) ? mod_max : load_val;
    end

    // Next-state selection with clr > load > step priority; tick/tc are single-cycle pulses.
    always_comb begin
        q_d    = q_q;
        tick_d = 1'b0;
        tc_d   = 1'b0;
        if (clr) begin
            q_d = '0;
        end else if (load) begin
            q_d = load_clamped;
        end else if (step) begin
            q_d    = step_val;
            tick_d = 1'b1;
            tc_d   = step_tc;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q    <= '0;
            pcnt_q <= '0;
            tick_q <= 1'b0;
            tc_q   <= 1'b0;
        end else begin
            q_q    <= q_d;
            pcnt_q <= pcnt_d;
            tick_q <= tick_d;
            tc_q   <= tc_d;
        end
    end

    assign q       = q_q;
    assign tick    = tick_q;
    assign tc      = tc_q;
    assign at_max  = (q_q == mod_max);
    assign at_zero = (q_q == '0);

endmodule

// File: tb/tb_sync_updown_counter_mod.sv
// Directed bench for sync_updown_counter_mod at WIDTH=4, PRESCALE_W=4.
// Inputs change on the falling edge; outputs are checked on the following falling edge.
// Each task checks one feature against hand-computed expected values.
module tb_sync_updown_counter_mod;

    logic       clk;
    logic       reset_n;
    logic       en;
    logic       clr;
    logic       load;
    logic [3:0] load_val;
    logic       up_dn;
    logic       sat;
    logic [3:0] mod_max;
    logic [3:0] div;
    logic [3:0] q;
    logic       tick;
    logic       tc;
    logic       at_max;
    logic       at_zero;

    int tests;
    int fails;

    sync_updown_counter_mod #(
        .WIDTH      (4),
        .PRESCALE_W (4)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .up_dn    (up_dn),
        .sat      (sat),
        .mod_max  (mod_max),
        .div      (div),
        .q        (q),
        .tick     (tick),
        .tc       (tc),
        .at_max   (at_max),
        .at_zero  (at_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        repeat (2) @(negedge clk);
        if ({q, tick, tc, at_zero, at_max} !== {4'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL reset_state q/tick/tc/zero/max=%0d/%b/%b/%b/%b want 0/0/0/1/0", q, tick, tc, at_zero, at_max);
        end
        tests++;
        reset_n = 1'b1;
        @(negedge clk);
        if ({q, tick, tc} !== {4'd0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_release_idle q/tick/tc=%0d/%b/%b want 0/0/0", q, tick, tc);
        end
        tests++;
    endtask

    task automatic test_basic();
        logic [3:0] eq;
        en = 1'b1; up_dn = 1'b1; sat = 1'b0; mod_max = 4'd9; div = 4'd0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            eq = 4'((i + 1) % 10);
            if ({q, tick, tc} !== {eq, 1'b1, (eq == 4'd0)}) begin
                fails++;
                $display("FAIL basic_wrap[%0d] q/tick/tc=%0d/%b/%b want %0d/1/%b", i, q, tick, tc, eq, (eq == 4'd0));
            end
            tests++;
        end
        repeat (3) @(negedge clk);
        if (q !== 4'd3) begin
            fails++;
            $display("FAIL basic_midcount q=%0d want 3", q);
        end
        tests++;
        #2 reset_n = 1'b0;
        #1;
        if ({q, tick, tc} !== {4'd0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL async_reset q/tick/tc=%0d/%b/%b want 0/0/0", q, tick, tc);
        end
        tests++;
        @(negedge clk);
        if (q !== 4'd0) begin
            fails++;
            $display("FAIL reset_held q=%0d want 0", q);
        end
        tests++;
        reset_n = 1'b1;
        @(negedge clk);
        if ({q, tick, tc} !== {4'd1, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL after_reset_step q/tick/tc=%0d/%b/%b want 1/1/0", q, tick, tc);
        end
        tests++;
    endtask

    task automatic test_prescale();
        logic [3:0] eq;
        logic       st;
        clr = 1'b1; mod_max = 4'd3; div = 4'd2;
        @(negedge clk);
        if ({q, tick} !== {4'd0, 1'b0}) begin
            fails++;
            $display("FAIL prescale_clr q/tick=%0d/%b want 0/0", q, tick);
        end
        tests++;
        clr = 1'b0;
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            st = (i % 3 == 0);
            eq = 4'((i / 3) % 4);
            if ({q, tick, tc} !== {eq, st, st && (eq == 4'd0)}) begin
                fails++;
                $display("FAIL prescale[%0d] q/tick/tc=%0d/%b/%b want %0d/%b/%b", i, q, tick, tc, eq, st, st && (eq == 4'd0));
            end
            tests++;
        end
        @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if ({q, tick, tc} !== {4'd0, 1'b0, 1'b0}) begin
                fails++;
                $display("FAIL prescale_frozen[%0d] q/tick/tc=%0d/%b/%b want 0/0/0", i, q, tick, tc);
            end
            tests++;
        end
        en = 1'b1;
        @(negedge clk);
        if ({q, tick} !== {4'd0, 1'b0}) begin
            fails++;
            $display("FAIL prescale_phase_kept q/tick=%0d/%b want 0/0", q, tick);
        end
        tests++;
        @(negedge clk);
        if ({q, tick} !== {4'd1, 1'b1}) begin
            fails++;
            $display("FAIL prescale_resume q/tick=%0d/%b want 1/1", q, tick);
        end
        tests++;
        div = 4'd3;
        repeat (2) @(negedge clk);
        if ({q, tick} !== {4'd1, 1'b0}) begin
            fail_note_div();
        end
        tests++;
        div = 4'd1;
        @(negedge clk);
        if ({q, tick} !== {4'd2, 1'b1}) begin
            fails++;
            $display("FAIL prescale_div_lowered q/tick=%0d/%b want 2/1", q, tick);
        end
        tests++;
    endtask

    task automatic fail_note_div();
        fails++;
        $display("FAIL prescale_div_raised q/tick=%0d/%b want 1/0", q, tick);
    endtask

    task automatic test_saturate();
        logic [3:0] eq;
        en = 1'b0; sat = 1'b1; mod_max = 4'd5; div = 4'd0; up_dn = 1'b1;
        load = 1'b1; load_val = 4'd3;
        @(negedge clk);
        if ({q, tick, tc} !== {4'd3, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL sat_load q/tick/tc=%0d/%b/%b want 3/0/0", q, tick, tc);
        end
        tests++;
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            eq = (i == 0) ? 4'd4 : 4'd5;
            if ({q, tick, tc, at_max} !== {eq, 1'b1, (i == 1), (eq == 4'd5)}) begin
                fails++;
                $display("FAIL sat_up[%0d] q/tick/tc/max=%0d/%b/%b/%b want %0d/1/%b/%b", i, q, tick, tc, at_max, eq, (i == 1), (eq == 4'd5));
            end
            tests++;
        end
        up_dn = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            eq = (i < 4) ? 4'(4 - i) : 4'd0;
            if ({q, tick, tc, at_zero} !== {eq, 1'b1, (i == 4), (eq == 4'd0)}) begin
                fails++;
                $display("FAIL sat_down[%0d] q/tick/tc/zero=%0d/%b/%b/%b want %0d/1/%b/%b", i, q, tick, tc, at_zero, eq, (i == 4), (eq == 4'd0));
            end
            tests++;
        end
    endtask

    task automatic test_down_wrap();
        logic [3:0] eq;
        sat = 1'b0; mod_max = 4'd7; en = 1'b0; load = 1'b1; load_val = 4'd1;
        @(negedge clk);
        if (q !== 4'd1) begin
            fails++;
            $display("FAIL dwrap_load q=%0d want 1", q);
        end
        tests++;
        load = 1'b0; en = 1'b1; up_dn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            eq = (i == 0) ? 4'd0 : ((i == 1) ? 4'd7 : 4'd6);
            if ({q, tick, tc} !== {eq, 1'b1, (i == 1)}) begin
                fails++;
                $display("FAIL dwrap[%0d] q/tick/tc=%0d/%b/%b want %0d/1/%b", i, q, tick, tc, eq, (i == 1));
            end
            tests++;
        end
    endtask

    task automatic test_priority();
        div = 4'd1; mod_max = 4'd9; up_dn = 1'b1; sat = 1'b0; en = 1'b1;
        @(negedge clk);
        if ({q, tick} !== {4'd6, 1'b0}) begin
            fails++;
            $display("FAIL prio_setup q/tick=%0d/%b want 6/0", q, tick);
        end
        tests++;
        clr = 1'b1; load = 1'b1; load_val = 4'd12;
        @(negedge clk);
        if ({q, tick, tc} !== {4'd0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL prio_clr_wins q/tick/tc=%0d/%b/%b want 0/0/0", q, tick, tc);
        end
        tests++;
        clr = 1'b0;
        @(negedge clk);
        if ({q, tick, tc, at_max} !== {4'd9, 1'b0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL prio_load_clamp q/tick/tc/max=%0d/%b/%b/%b want 9/0/0/1", q, tick, tc, at_max);
        end
        tests++;
        load = 1'b0;
        @(negedge clk);
        if ({q, tick} !== {4'd9, 1'b0}) begin
            fails++;
            $display("FAIL prio_pcnt_cleared q/tick=%0d/%b want 9/0", q, tick);
        end
        tests++;
        @(negedge clk);
        if ({q, tick, tc} !== {4'd0, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL prio_wrap_after_load q/tick/tc=%0d/%b/%b want 0/1/1", q, tick, tc);
        end
        tests++;
    endtask

    task automatic test_runtime_mod();
        div = 4'd0; en = 1'b0; mod_max = 4'd9; load = 1'b1; load_val = 4'd8;
        @(negedge clk);
        if (q !== 4'd8) begin
            fails++;
            $display("FAIL rmod_load1 q=%0d want 8", q);
        end
        tests++;
        load = 1'b0; mod_max = 4'd4; en = 1'b1; up_dn = 1'b1; sat = 1'b0;
        @(negedge clk);
        if ({q, tick, tc} !== {4'd0, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL rmod_up q/tick/tc=%0d/%b/%b want 0/1/1", q, tick, tc);
        end
        tests++;
        en = 1'b0; load = 1'b1; mod_max = 4'd9; load_val = 4'd8;
        @(negedge clk);
        if (q !== 4'd8) begin
            fails++;
            $display("FAIL rmod_load2 q=%0d want 8", q);
        end
        tests++;
        load = 1'b0; en = 1'b1; mod_max = 4'd4; up_dn = 1'b0;
        @(negedge clk);
        if ({q, tick, tc, at_max} !== {4'd4, 1'b1, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL rmod_down q/tick/tc/max=%0d/%b/%b/%b want 4/1/0/1", q, tick, tc, at_max);
        end
        tests++;
    endtask

    task automatic test_boundaries();
        mod_max = 4'd0; en = 1'b1; up_dn = 1'b1; sat = 1'b0; div = 4'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if ({q, tick, tc} !== {4'd0, 1'b1, 1'b1}) begin
                fails++;
                $display("FAIL mod0_wrap[%0d] q/tick/tc=%0d/%b/%b want 0/1/1", i, q, tick, tc);
            end
            tests++;
        end
        sat = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if ({q, tick, tc} !== {4'd0, 1'b1, 1'b0}) begin
                fails++;
                $display("FAIL mod0_sat[%0d] q/tick/tc=%0d/%b/%b want 0/1/0", i, q, tick, tc);
            end
            tests++;
        end
        sat = 1'b0; up_dn = 1'b0;
        @(negedge clk);
        if ({q, tick, tc} !== {4'd0, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL mod0_down q/tick/tc=%0d/%b/%b want 0/1/1", q, tick, tc);
        end
        tests++;
        mod_max = 4'd15; en = 1'b0; load = 1'b1; load_val = 4'd14; up_dn = 1'b1;
        @(negedge clk);
        load = 1'b0; en = 1'b1;
        @(negedge clk);
        if ({q, tick, tc, at_max} !== {4'd15, 1'b1, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL full_range_top q/tick/tc/max=%0d/%b/%b/%b want 15/1/0/1", q, tick, tc, at_max);
        end
        tests++;
        @(negedge clk);
        if ({q, tick, tc} !== {4'd0, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL full_range_wrap q/tick/tc=%0d/%b/%b want 0/1/1", q, tick, tc);
        end
        tests++;
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        reset_n  = 1'b0;
        en       = 1'b0;
        clr      = 1'b0;
        load     = 1'b0;
        load_val = 4'd0;
        up_dn    = 1'b1;
        sat      = 1'b0;
        mod_max  = 4'd9;
        div      = 4'd0;
        test_reset();
        test_basic();
        test_prescale();
        test_saturate();
        test_down_wrap();
        test_priority();
        test_runtime_mod();
        test_boundaries();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sync_updown_counter_mod.md
Name: sync_updown_counter_mod

Overview:
Parametrised synchronous up/down counter with a runtime-programmable modulus, wrap or saturate mode, and a clock-enable prescaler. It replaces the fixed 4-bit free-running up counter wherever a divider, timeout or event counter is needed. It emits a registered terminal-count pulse for cascading and interrupt generation.

Parameters:
WIDTH, 8, counter width in bits (>=2)
PRESCALE_W, 4, prescaler divide-select width in bits (>=1)

Ports:
clk  input  1  clock; all state updates on rising edge
reset_n  input  1  reset; one clock; reset is asynchronous and active-low
en  input  1  count enable; low holds q and prescaler state
clr  input  1  synchronous clear
load  input  1  synchronous load strobe
load_val  input  WIDTH  value captured on load
up_dn  input  1  direction: 1 = up, 0 = down
sat  input  1  mode: 1 = saturate at range ends, 0 = wrap
mod_max  input  WIDTH  count range is 0..mod_max inclusive
div  input  PRESCALE_W  q steps once every (div+1) enabled cycles
q  output  WIDTH  registered count
tick  output  1  registered; high for the cycle in which q shows a step result
tc  output  1  registered terminal-count pulse, one cycle wide
at_max  output  1  combinational, q == mod_max
at_zero  output  1  combinational, q == 0

Behaviour:
- Reset (reset_n low, asynchronous): q=0, internal prescaler pcnt=0, tick=0, tc=0. Release is synchronous to the next clk edge. Reset mid-count discards all state.
- Priority per edge: clr > load > step. tick and tc default to 0 every cycle unless set by a step.
- clr: q=0, pcnt=0. Applies regardless of en.
- load: q=min(load_val, mod_max), pcnt=0. Applies regardless of en. No tc.
- Prescaler: when en=1 and no clr/load, if pcnt==div then step and pcnt=0; else pcnt=pcnt+1. div=0 steps every enabled cycle. A runtime change of div takes effect on the next compare. If pcnt>div after div is lowered, treat it as a match.
- Step, up_dn=1:
  - q<mod_max: q=q+1. tc=1 if sat=1 and the new q==mod_max.
  - q>=mod_max, wrap mode: q=0, tc=1.
  - q>=mod_max, sat mode: q=mod_max, tc=0.
- Step, up_dn=0:
  - q>mod_max: q=mod_max, no tc.
  - 0<q<=mod_max: q=q-1. tc=1 if sat=1 and the new q==0.
  - q==0, wrap mode: q=mod_max, tc=1.
  - q==0, sat mode: hold at 0, tc=0.
- tick=1 on every step edge, including held-saturated steps.
- mod_max==0: q stays 0. Wrap mode gives tc=1 on every step; sat mode gives tc=0.
- Arithmetic is WIDTH bits, with no overflow beyond mod_max. mod_max=all-ones gives a full 2^WIDTH range.
- up_dn, sat and mod_max are sampled each edge; mid-count changes take effect immediately.
- Latency: tick and tc coincide with the first cycle q shows the new value.

Test Plan:
- Reset/basic (WIDTH=4, mod_max=9, div=0, up, wrap, en=1): pulse reset_n low mid-count -> q=0 at once. Then q runs 0..9,0 with tc=1 only in the cycle q becomes 0, period 10 cycles.
- Prescale: div=2, mod_max=3, up, wrap -> q increments every 3rd cycle, with tick high on those cycles. tc fires every 12 cycles. en low for 5 cycles -> q and phase frozen.
- Saturate: sat=1, mod_max=5, up from 3 -> q 4,5,5,5 with tc only on the 4->5 step. Switch to down -> q 4..0 with tc on the 1->0 step, then holds 0.
- Down wrap: sat=0, mod_max=7, down from 1 -> q 0,7,6 with tc on the 0->7 step.
- Priority/load: assert clr, load=1 (load_val=12) and en=1 in the same cycle with mod_max=9 -> q=0. Next cycle load alone -> q=9 (clamped), pcnt=0, tc=0.
- Runtime modulus: q=8, mod_max changed to 4 -> up wrap step gives q=0 with tc=1; down step gives q=4.
